// File: rtl/audio_pkg.sv
// Shared types for the audio DAC serializer.
// AUD_I2S_MODE_EN selects I2S framing (left phase = LRCK low); undefined gives left-justified.
package audio_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } dac_state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  // Channel entered on an LRCK edge, given whether that edge was rising.
  function automatic channel_t edge_channel(input logic lrck_rise);
`ifdef AUD_I2S_MODE_EN
    return lrck_rise ? CH_RIGHT : CH_LEFT;
`else
    return lrck_rise ? CH_LEFT : CH_RIGHT;
`endif
  endfunction

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample handshake between the filter datapath (master) and the DAC serializer (slave).
interface audio_dac_serializer_if
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] sample_inL;
  logic [DATA_WIDTH-1:0] sample_inR;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample_inL,
    output sample_inR,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_inL,
    input  sample_inR,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/edge_sync.sv
// Synchronizes one asynchronous codec clock into CLOCK_50 and emits registered rise/fall pulses.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_arm;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Pulses stay gated until the chain holds real pin history, so a pin already
  // high at reset release is not mistaken for an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_arm  <= '0;
      r_prev <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, i_async});
      r_arm  <= (SYNC_STAGES + 1)'({r_arm, 1'b1});
      r_prev <= w_level;
      o_rise <= r_arm[SYNC_STAGES] & w_level & ~r_prev;
      o_fall <= r_arm[SYNC_STAGES] & ~w_level & r_prev;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Double-buffers one stereo sample and shifts it MSB-first onto AUD_DACDAT, slaved to codec BCLK/LRCK.
// AUD_I2S_MODE_EN defined: I2S framing with a one-BCLK delay; undefined: left-justified framing.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                   CLOCK_50,
  input  logic                   Reset,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_DACLRCK,
  audio_dac_serializer_if.slave  smp,
  output logic                   AUD_DACDAT,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic                  w_bclk_rise_unused;
  logic                  w_bclk_fall;
  logic                  w_lrck_rise;
  logic                  w_lrck_fall;
  logic                  w_lrck_edge;
  logic                  w_left_edge;
  logic                  w_xfer;
  channel_t              w_chan;
  logic [DATA_WIDTH-1:0] w_next_L;
  logic [DATA_WIDTH-1:0] w_next_R;
  logic [DATA_WIDTH-1:0] w_word;

  dac_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_hold_L;
  logic [DATA_WIDTH-1:0] r_hold_R;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_cur_L;
  logic [DATA_WIDTH-1:0] r_cur_R;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .i_clk   (CLOCK_50),
    .i_rst   (Reset),
    .i_async (AUD_BCLK),
    .o_rise  (w_bclk_rise_unused),
    .o_fall  (w_bclk_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .i_clk   (CLOCK_50),
    .i_rst   (Reset),
    .i_async (AUD_DACLRCK),
    .o_rise  (w_lrck_rise),
    .o_fall  (w_lrck_fall)
  );

  assign w_lrck_edge = w_lrck_rise | w_lrck_fall;
  assign w_chan      = edge_channel(w_lrck_rise);
  assign w_left_edge = w_lrck_edge && (w_chan == CH_LEFT);
  assign w_xfer      = smp.sample_valid && !r_hold_full;

  // The word loaded at a frame start must already be the freshly promoted sample.
  assign w_next_L = (w_left_edge && r_hold_full) ? r_hold_L : r_cur_L;
  assign w_next_R = (w_left_edge && r_hold_full) ? r_hold_R : r_cur_R;
  assign w_word   = (w_chan == CH_LEFT) ? w_next_L : w_next_R;

  assign smp.sample_ready = !r_hold_full;

  // Holding register, frame bookkeeping and the serial shift FSM.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_hold_L    <= '0;
      r_hold_R    <= '0;
      r_hold_full <= 1'b0;
      r_cur_L     <= '0;
      r_cur_R     <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      AUD_DACDAT  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= w_left_edge;
      underrun    <= w_left_edge && !r_hold_full;
      r_cur_L     <= w_next_L;
      r_cur_R     <= w_next_R;

      if (w_left_edge && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_xfer) begin
        r_hold_full <= 1'b1;
        r_hold_L    <= smp.sample_inL;
        r_hold_R    <= smp.sample_inR;
      end

      if (w_lrck_edge && (r_state != IDLE || w_left_edge)) begin
        r_cnt <= '0;
`ifdef AUD_I2S_MODE_EN
        r_shift    <= w_word;
        AUD_DACDAT <= 1'b0;
        r_state    <= DELAY;
`else
        r_shift    <= {w_word[DATA_WIDTH-2:0], 1'b0};
        AUD_DACDAT <= w_word[DATA_WIDTH-1];
        r_state    <= SHIFT;
`endif
      end else if (w_bclk_fall) begin
        case (r_state)
          DELAY: begin
            AUD_DACDAT <= r_shift[DATA_WIDTH-1];
            r_shift    <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            r_state    <= SHIFT;
          end
          SHIFT: begin
            if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              AUD_DACDAT <= 1'b0;
              r_state    <= PAD;
            end else begin
              AUD_DACDAT <= r_shift[DATA_WIDTH-1];
              r_shift    <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              r_cnt      <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            AUD_DACDAT <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer; honours AUD_I2S_MODE_EN for framing expectations.
module tb_audio_dac_serializer;

`ifdef AUD_I2S_MODE_EN
  localparam logic LEFT_LV = 1'b0;
`else
  localparam logic LEFT_LV = 1'b1;
`endif
  localparam logic RIGHT_LV = ~LEFT_LV;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic bclk = 1'b1;
  logic lrck = LEFT_LV;
  logic dacdat;
  logic fs;
  logic ur;

  int   errors = 0;
  int   checks = 0;
  int   fs_cnt = 0;
  int   ur_cnt = 0;
  int   rdy_after_cnt = 0;
  logic fs_d = 1'b0;

  audio_dac_serializer_if #(.DATA_WIDTH(16)) smp ();

  audio_dac_serializer #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (lrck),
    .smp         (smp),
    .AUD_DACDAT  (dacdat),
    .frame_start (fs),
    .underrun    (ur)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    fs_d <= fs;
    if (fs_d && smp.sample_ready) rdy_after_cnt <= rdy_after_cnt + 1;
    if (fs) fs_cnt <= fs_cnt + 1;
    if (ur) ur_cnt <= ur_cnt + 1;
  end

  function automatic logic [31:0] exp_full(input logic [15:0] w);
`ifdef AUD_I2S_MODE_EN
    exp_full = {1'b0, w, 15'h0000};
`else
    exp_full = {w, 16'h0000};
`endif
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    smp.sample_inL   = l;
    smp.sample_inR   = r;
    smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_valid = 1'b0;
    @(negedge clk);
  endtask

  // One LRCK slot of nb BCLKs (half period 8 cycles); bits are the values seen at each BCLK rise.
  task automatic run_slot(input logic lr, input int nb, input logic inj,
                          input logic [15:0] il, input logic [15:0] ir,
                          output logic [31:0] bits, output int lat);
    logic prev;
    bits = '0;
    lat  = 0;
    for (int b = 0; b < nb; b++) begin
      prev = dacdat;
      bclk = 1'b0;
      if (b == 0) lrck = lr;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (inj && b == 0 && i == 3) begin
          smp.sample_inL   = il;
          smp.sample_inR   = ir;
          smp.sample_valid = 1'b1;
        end
        if (inj && b == 0 && i == 4) smp.sample_valid = 1'b0;
        if (b == 1 && lat == 0 && dacdat !== prev) lat = i;
      end
      bits = {bits[30:0], dacdat};
      bclk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat: got %b expected 0", dacdat); end
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", smp.sample_ready); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", fs); end
    checks++; if (ur !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", ur); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_idle();
    logic [31:0] bits;
    int lat;
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== 32'h0000_0000) begin errors++; $display("FAIL idle_right_edge: got %h expected 00000000", bits); end
    checks++; if (fs_cnt !== 0) begin errors++; $display("FAIL idle_frame_count: got %0d expected 0", fs_cnt); end
  endtask

  task automatic test_basic();
    logic [31:0] bits;
    int lat;
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_pre: got %b expected 1", smp.sample_ready); end
    push(16'hA5F0, 16'h0001);
    checks++; if (smp.sample_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_full: got %b expected 0", smp.sample_ready); end
    run_slot(LEFT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'hA5F0)) begin errors++; $display("FAIL basic_left: got %h expected %h", bits, exp_full(16'hA5F0)); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (fs_cnt !== 1) begin errors++; $display("FAIL basic_frame_count: got %0d expected 1", fs_cnt); end
    checks++; if (ur_cnt !== 0) begin errors++; $display("FAIL basic_underrun_count: got %0d expected 0", ur_cnt); end
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_post: got %b expected 1", smp.sample_ready); end
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h0001)) begin errors++; $display("FAIL basic_right: got %h expected %h", bits, exp_full(16'h0001)); end
  endtask

  task automatic test_underrun();
    logic [31:0] bits;
    int lat;
    run_slot(LEFT_LV, 32, 1'b1, 16'h3C5A, 16'h8001, bits, lat);
    checks++; if (bits !== exp_full(16'hA5F0)) begin errors++; $display("FAIL underrun_repeat_left: got %h expected %h", bits, exp_full(16'hA5F0)); end
    checks++; if (ur_cnt !== 1) begin errors++; $display("FAIL underrun_count: got %0d expected 1", ur_cnt); end
    checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL underrun_frame_count: got %0d expected 2", fs_cnt); end
    checks++; if (smp.sample_ready !== 1'b0) begin errors++; $display("FAIL underrun_hold_full: got %b expected 0", smp.sample_ready); end
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h0001)) begin errors++; $display("FAIL underrun_repeat_right: got %h expected %h", bits, exp_full(16'h0001)); end
    run_slot(LEFT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h3C5A)) begin errors++; $display("FAIL frame3_left: got %h expected %h", bits, exp_full(16'h3C5A)); end
    checks++; if (ur_cnt !== 1) begin errors++; $display("FAIL frame3_underrun_count: got %0d expected 1", ur_cnt); end
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h8001)) begin errors++; $display("FAIL frame3_right: got %h expected %h", bits, exp_full(16'h8001)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits;
    int lat;
    int rdy0;
    push(16'h1111, 16'h7FFF);
    checks++; if (smp.sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_first: got %b expected 0", smp.sample_ready); end
    push(16'h2222, 16'h2222);
    checks++; if (smp.sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_second: got %b expected 0", smp.sample_ready); end
    rdy0 = rdy_after_cnt;
    run_slot(LEFT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h1111)) begin errors++; $display("FAIL b2b_left: got %h expected %h", bits, exp_full(16'h1111)); end
    checks++; if (rdy_after_cnt !== rdy0 + 1) begin errors++; $display("FAIL b2b_ready_after_fs: got %0d expected %0d", rdy_after_cnt, rdy0 + 1); end
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h7FFF)) begin errors++; $display("FAIL b2b_right: got %h expected %h", bits, exp_full(16'h7FFF)); end
  endtask

  task automatic test_truncate();
    logic [31:0] bits;
    int lat;
    push(16'hC3A5, 16'h9C35);
    run_slot(LEFT_LV, 10, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== (exp_full(16'hC3A5) >> 22)) begin errors++; $display("FAIL trunc_left: got %h expected %h", bits, exp_full(16'hC3A5) >> 22); end
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h9C35)) begin errors++; $display("FAIL trunc_right: got %h expected %h", bits, exp_full(16'h9C35)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits;
    int lat;
    int fs0;
    int ur0;
    push(16'hFFFF, 16'hFFFF);
    run_slot(LEFT_LV, 3, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (dacdat !== 1'b1) begin errors++; $display("FAIL rstmid_shifting: got %b expected 1", dacdat); end
    push(16'h1234, 16'h1234);
    #2 rst = 1'b1;
    #1;
    checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL rstmid_async_dacdat: got %b expected 0", dacdat); end
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async_ready: got %b expected 1", smp.sample_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    fs0 = fs_cnt;
    ur0 = ur_cnt;
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== 32'h0000_0000) begin errors++; $display("FAIL rstmid_idle_bits: got %h expected 00000000", bits); end
    checks++; if (fs_cnt !== fs0) begin errors++; $display("FAIL rstmid_idle_frames: got %0d expected %0d", fs_cnt, fs0); end
    push(16'h8421, 16'h4218);
    run_slot(LEFT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h8421)) begin errors++; $display("FAIL rstmid_left: got %h expected %h", bits, exp_full(16'h8421)); end
    checks++; if (ur_cnt !== ur0) begin errors++; $display("FAIL rstmid_underrun: got %0d expected %0d", ur_cnt, ur0); end
    run_slot(RIGHT_LV, 32, 1'b0, 16'h0000, 16'h0000, bits, lat);
    checks++; if (bits !== exp_full(16'h4218)) begin errors++; $display("FAIL rstmid_right: got %h expected %h", bits, exp_full(16'h4218)); end
  endtask

  initial begin
    smp.sample_inL   = 16'h0000;
    smp.sample_inR   = 16'h0000;
    smp.sample_valid = 1'b0;
    test_reset();
    test_idle();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_truncate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
